// File: rtl/vec_dot_pkg.sv
// Shared types and sizing helpers for the integer dot-product back end.
package vec_dot_pkg;

  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

  function automatic int tree_levels(input int length);
    return $clog2(length);
  endfunction

  function automatic int sum_width(input int prd_width, input int length);
    return prd_width + tree_levels(length);
  endfunction

endpackage

// File: rtl/vec_dot_acc_int_if.sv
// Product-vector input and dot-product output handshake bundle.
// Optional o_sat member exists only when VEC_DOT_ACC_SAT_EN is defined.
interface vec_dot_acc_int_if #(
  parameter int prd_width = 16,
  parameter int length    = 32,
  parameter int acc_width = 32
);
  logic signed [prd_width-1:0] i_prd [length];
  logic                        i_valid;
  logic                        i_last;
  logic                        o_ready;
  logic signed [acc_width-1:0] o_dot;
  logic                        o_valid;
  logic                        i_ready;
`ifdef VEC_DOT_ACC_SAT_EN
  logic                        o_sat;

  modport slave  (input i_prd, i_valid, i_last, i_ready,
                  output o_ready, o_dot, o_valid, o_sat);
  modport master (output i_prd, i_valid, i_last, i_ready,
                  input o_ready, o_dot, o_valid, o_sat);
`else
  modport slave  (input i_prd, i_valid, i_last, i_ready,
                  output o_ready, o_dot, o_valid);
  modport master (output i_prd, i_valid, i_last, i_ready,
                  input o_ready, o_dot, o_valid);
`endif
endinterface

// File: rtl/add_tree_int.sv
// Pipelined signed pairwise adder tree; one register level per halving, all gated by en.
// Each level grows one bit and carries the valid/last tag alongside the data.
module add_tree_int
  import vec_dot_pkg::*;
#(
  parameter int prd_width = 16,
  parameter int length    = 32
) (
  input  logic                                          clk,
  input  logic                                          srst,
  input  logic                                          en,
  input  logic signed [prd_width-1:0]                   in_prd [length],
  input  tag_t                                          in_tag,
  output logic signed [sum_width(prd_width,length)-1:0] out_sum,
  output tag_t                                          out_tag
);
  localparam int levels = tree_levels(length);

  genvar gi;
  generate
    for (gi = 0; gi <= levels; gi++) begin : g_lvl
      localparam int w = prd_width + gi;
      localparam int n = length >> gi;
      logic signed [w-1:0] sum [n];
      tag_t                tag;

      if (gi == 0) begin : g_in
        always_comb begin
          for (int j = 0; j < n; j++) sum[j] = in_prd[j];
          tag = in_tag;
        end
      end else begin : g_reg
        // Only the tag needs reset; data behind a cleared valid is never consumed.
        always_ff @(posedge clk) begin
          if (srst) tag <= '0;
          else if (en) tag <= g_lvl[gi-1].tag;
          if (en) begin
            for (int j = 0; j < n; j++) begin
              sum[j] <= {g_lvl[gi-1].sum[2*j][w-2],   g_lvl[gi-1].sum[2*j]}
                      + {g_lvl[gi-1].sum[2*j+1][w-2], g_lvl[gi-1].sum[2*j+1]};
            end
          end
        end
      end
    end
  endgenerate

  assign out_sum = g_lvl[levels].sum[0];
  assign out_tag = g_lvl[levels].tag;
endmodule

// File: rtl/vec_dot_acc_int.sv
// Integer dot-product back end: adder tree + group accumulator + valid/ready output.
// Define VEC_DOT_ACC_SAT_EN for saturating accumulation and the o_sat flag.
module vec_dot_acc_int
  import vec_dot_pkg::*;
#(
  parameter int prd_width = 16,
  parameter int length    = 32,
  parameter int acc_width = 32
) (
  input logic              i_clk,
  input logic              i_rst,
  vec_dot_acc_int_if.slave bus
);
  localparam int sw = sum_width(prd_width, length);

  logic                        en;
  tag_t                        in_tag;
  tag_t                        tree_tag;
  logic signed [sw-1:0]        tree_sum;

  logic signed [acc_width-1:0] acc_reg;
  logic signed [acc_width-1:0] acc_next;
  logic signed [acc_width-1:0] base;
  logic signed [acc_width-1:0] addend;
  logic signed [acc_width-1:0] dot_reg;
  logic                        first_reg;
  logic                        o_valid_reg;

  // A single enable freezes the tree and the output stage together while blocked.
  assign en          = !o_valid_reg || bus.i_ready;
  assign bus.o_ready = en;
  assign in_tag      = tag_t'{valid: bus.i_valid, last: bus.i_last};

  add_tree_int #(
    .prd_width (prd_width),
    .length    (length)
  ) u_tree (
    .clk     (i_clk),
    .srst    (i_rst),
    .en      (en),
    .in_prd  (bus.i_prd),
    .in_tag  (in_tag),
    .out_sum (tree_sum),
    .out_tag (tree_tag)
  );

`ifdef VEC_DOT_ACC_SAT_EN
  localparam logic signed [acc_width-1:0] sat_max = {1'b0, {(acc_width-1){1'b1}}};
  localparam logic signed [acc_width-1:0] sat_min = {1'b1, {(acc_width-1){1'b0}}};
  logic signed [acc_width:0] wide;
  logic                      sat_now;
  logic                      sat_reg;
  logic                      sat_next;
  logic                      o_sat_reg;
  assign bus.o_sat = o_sat_reg;
`endif

  always_comb begin
    base   = first_reg ? '0 : acc_reg;
    addend = acc_width'(tree_sum);
`ifdef VEC_DOT_ACC_SAT_EN
    // One guard bit exposes overflow: the top two bits differ only when out of range.
    wide    = {base[acc_width-1], base} + {addend[acc_width-1], addend};
    sat_now = wide[acc_width] != wide[acc_width-1];
    if (sat_now) acc_next = wide[acc_width] ? sat_min : sat_max;
    else         acc_next = wide[acc_width-1:0];
    sat_next = (first_reg ? 1'b0 : sat_reg) | sat_now;
`else
    acc_next = base + addend;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_reg     <= '0;
      dot_reg     <= '0;
      first_reg   <= 1'b1;
      o_valid_reg <= 1'b0;
`ifdef VEC_DOT_ACC_SAT_EN
      sat_reg     <= 1'b0;
      o_sat_reg   <= 1'b0;
`endif
    end else if (en) begin
      if (tree_tag.valid) begin
        acc_reg   <= acc_next;
        first_reg <= tree_tag.last;
`ifdef VEC_DOT_ACC_SAT_EN
        sat_reg   <= sat_next;
`endif
      end
      // en with o_valid set implies i_ready, so a pending result is being taken here.
      if (tree_tag.valid && tree_tag.last) begin
        dot_reg     <= acc_next;
        o_valid_reg <= 1'b1;
`ifdef VEC_DOT_ACC_SAT_EN
        o_sat_reg   <= sat_next;
`endif
      end else if (bus.i_ready) begin
        o_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.o_dot   = dot_reg;
  assign bus.o_valid = o_valid_reg;
endmodule

// File: tb/tb_vec_dot_acc_int.sv
// Self-checking bench for vec_dot_acc_int: scoreboard model plus directed literal checks.
module tb_vec_dot_acc_int;
  localparam int prd_w = 16;
  localparam int len   = 4;
  localparam int acc_w = 18;
  localparam longint amax = (longint'(1) <<< (acc_w - 1)) - 1;
  localparam longint amin = -(longint'(1) <<< (acc_w - 1));

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vec_dot_acc_int_if #(.prd_width(prd_w), .length(len), .acc_width(acc_w)) bus ();

  vec_dot_acc_int #(.prd_width(prd_w), .length(len), .acc_width(acc_w)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    longint dot;
    bit     sat;
  } res_t;

  res_t   exp_q[$];
  longint got_q[$];
  bit     last_sat;
  longint m_acc   = 0;
  bit     m_first = 1'b1;
  bit     m_sat   = 1'b0;
  int     n_cmp   = 0;
  int     n_bad   = 0;
  bit     rnd_done = 1'b0;

  function automatic void check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic longint wrap(input longint x);
    longint m;
    m = x & ((longint'(1) <<< acc_w) - 1);
    if (m > amax) m = m - (longint'(1) <<< acc_w);
    return m;
  endfunction

  // Reference model: group sum of all accepted elements, wrapped or clamped per vector.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_acc   = 0;
      m_first = 1'b1;
      m_sat   = 1'b0;
    end else begin
      check("o_ready", longint'(bus.o_ready), longint'(!bus.o_valid || bus.i_ready));
      if (bus.o_valid && bus.i_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got %0d, expected no result", bus.o_dot);
        end else begin
          res_t r;
          r = exp_q.pop_front();
          check("o_dot", longint'(bus.o_dot), r.dot);
`ifdef VEC_DOT_ACC_SAT_EN
          check("o_sat", longint'(bus.o_sat), longint'(r.sat));
          last_sat = bus.o_sat;
`endif
        end
        got_q.push_back(longint'(bus.o_dot));
      end
      if (bus.i_valid && bus.o_ready) begin
        longint s;
        s = 0;
        for (int j = 0; j < len; j++) s += longint'(bus.i_prd[j]);
        if (m_first) begin
          m_acc = 0;
          m_sat = 1'b0;
        end
        m_acc += s;
`ifdef VEC_DOT_ACC_SAT_EN
        if (m_acc > amax) begin m_acc = amax; m_sat = 1'b1; end
        if (m_acc < amin) begin m_acc = amin; m_sat = 1'b1; end
`else
        m_acc = wrap(m_acc);
`endif
        m_first = bus.i_last;
        if (bus.i_last) exp_q.push_back('{m_acc, m_sat});
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that transferred the vector.
  task automatic send(input logic signed [prd_w-1:0] v [len], input logic last);
    int  k;
    bit  ok;
    for (int j = 0; j < len; j++) bus.i_prd[j] = v[j];
    bus.i_last  = last;
    bus.i_valid = 1'b1;
    k  = 0;
    ok = 1'b0;
    while (!ok && k < 200) begin
      @(negedge clk);
      if (bus.o_ready) ok = 1'b1;
      k++;
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got o_ready=0 for %0d cycles, expected 1", k);
    end
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill(output logic signed [prd_w-1:0] v [len], input longint val);
    for (int j = 0; j < len; j++) v[j] = prd_w'(val);
  endtask

  logic signed [prd_w-1:0] vec [len];
  int n0;

  initial begin
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
    bus.i_ready = 1'b1;
    for (int j = 0; j < len; j++) bus.i_prd[j] = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_o_valid", longint'(bus.o_valid), 0);
    check("rst_o_dot", longint'(bus.o_dot), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", longint'(bus.o_ready), 1);
    @(posedge clk);
    #1;

    // Single vector {1,2,3,4}: result visible exactly in cycle t+3.
    n0 = got_q.size();
    vec = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
    send(vec, 1'b1);
    @(negedge clk); check("lat_t1_valid", longint'(bus.o_valid), 0);
    @(negedge clk); check("lat_t2_valid", longint'(bus.o_valid), 0);
    @(negedge clk); check("lat_t3_valid", longint'(bus.o_valid), 1);
    check("lat_t3_dot", longint'(bus.o_dot), 10);
    @(negedge clk); check("lat_t4_valid", longint'(bus.o_valid), 0);
    @(posedge clk); #1;
    check("single_count", longint'(got_q.size() - n0), 1);

    // Three-vector group -> one result of 1000.
    n0 = got_q.size();
    fill(vec, 100);  send(vec, 1'b0);
    fill(vec, 200);  send(vec, 1'b0);
    fill(vec, -50);  send(vec, 1'b1);
    idle(6);
    check("group3_count", longint'(got_q.size() - n0), 1);
    check("group3_dot", got_q[got_q.size() - 1], 1000);

    // Output stall: consumer blocked for 5 cycles, nothing lost.
    n0 = got_q.size();
    bus.i_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          for (int j = 0; j < len; j++) vec[j] = prd_w'($urandom);
          send(vec, 1'b1);
        end
      end
      begin
        int k;
        k = 0;
        while (!bus.o_valid && k < 50) begin
          @(negedge clk);
          k++;
        end
        repeat (5) begin
          @(negedge clk);
          check("stall_o_ready", longint'(bus.o_ready), 0);
        end
        @(posedge clk);
        #1 bus.i_ready = 1'b1;
      end
    join
    idle(10);
    check("stall_count", longint'(got_q.size() - n0), 8);

    // Reset mid-group discards the partial sum.
    n0 = got_q.size();
    fill(vec, 7); send(vec, 1'b0);
    fill(vec, 7); send(vec, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    fill(vec, 1); send(vec, 1'b1);
    idle(6);
    check("rst_mid_count", longint'(got_q.size() - n0), 1);
    check("rst_mid_dot", got_q[got_q.size() - 1], 4);

    // Signed extremes.
    fill(vec, -32768); send(vec, 1'b1);
    idle(6);
    check("neg_extreme_dot", got_q[got_q.size() - 1], -131072);
    fill(vec, -32768); send(vec, 1'b0);
    fill(vec, -32768); send(vec, 1'b1);
    idle(6);
`ifdef VEC_DOT_ACC_SAT_EN
    check("sat_dot", got_q[got_q.size() - 1], -131072);
    check("sat_flag", longint'(last_sat), 1);
`else
    check("wrap_dot", got_q[got_q.size() - 1], 0);
`endif

    // Random groups with random valid gaps and ready toggling.
    n0 = got_q.size();
    fork
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 bus.i_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int g = 0; g < 1000; g++) begin
          int nv;
          nv = $urandom_range(1, 4);
          for (int v = 0; v < nv; v++) begin
            repeat ($urandom_range(0, 2)) begin
              for (int j = 0; j < len; j++) bus.i_prd[j] = prd_w'($urandom);
              bus.i_last = 1'($urandom);
              @(posedge clk);
              #1;
            end
            case ($urandom_range(0, 9))
              0:       fill(vec, -32768);
              1:       fill(vec, 32767);
              default: for (int j = 0; j < len; j++) vec[j] = prd_w'($urandom);
            endcase
            send(vec, v == nv - 1);
          end
        end
        rnd_done = 1'b1;
      end
    join
    bus.i_ready = 1'b1;
    begin
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 300) begin
        @(posedge clk);
        k++;
      end
    end
    idle(2);
    check("random_drain", longint'(exp_q.size()), 0);
    check("random_count", longint'(got_q.size() - n0), 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish by time limit, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
